// File: rtl/sa_data_feeder_if.sv
// Shared operand-control types and the vector/array bundle used by the
// systolic-array left-edge feeder.
package matrix_cps_pkg;

    typedef enum logic [1:0] {
        DT_INT32 = 2'd0,
        DT_INT16 = 2'd1,
        DT_INT8  = 2'd2,
        DT_RSVD  = 2'd3
    } dtype_e;

    typedef struct packed {
        logic [1:0] op;
        dtype_e     dtype;
    } sa_ctrl_t;

endpackage

interface sa_data_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 4
);
    import matrix_cps_pkg::*;

    logic                         vec_valid_i;
    logic                         vec_ready_o;
    logic [N_ROWS*DATA_WIDTH-1:0] vec_data_i;
    logic                         vec_last_i;
    sa_ctrl_t                     sa_ctrl_i;
    logic                         stall_i;
    logic                         pump_o;
    logic [N_ROWS*DATA_WIDTH-1:0] data_o;
    sa_ctrl_t                     sa_ctrl_o;
    logic                         busy_o;
    logic                         done_o;

    modport master (
        output vec_valid_i, vec_data_i, vec_last_i, sa_ctrl_i, stall_i,
        input  vec_ready_o, pump_o, data_o, sa_ctrl_o, busy_o, done_o
    );

    modport slave (
        input  vec_valid_i, vec_data_i, vec_last_i, sa_ctrl_i, stall_i,
        output vec_ready_o, pump_o, data_o, sa_ctrl_o, busy_o, done_o
    );

endinterface

// File: rtl/sa_data_feeder.sv
// Left-edge transmitter for the systolic array: accepts row vectors, applies
// the triangular lane skew and flushes with zero columns after the last beat.
module sa_data_feeder
    import matrix_cps_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sa_data_feeder_if.slave   bus
);

    localparam int CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(N_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_e;

    state_e                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_pump;
    logic                         r_done;
    sa_ctrl_t                     r_ctrl;
    logic [N_ROWS*DATA_WIDTH-1:0] r_data;

    logic                         w_ready;
    logic                         w_hs;
    logic                         w_event;
    logic                         w_flush_end;
    logic                         w_final;
    logic [DATA_WIDTH-1:0]        w_inj  [N_ROWS];
    logic [DATA_WIDTH-1:0]        w_lane [N_ROWS];
    logic [N_ROWS*DATA_WIDTH-1:0] w_lane_flat;

    always_comb begin
        w_ready     = !bus.stall_i && (r_state != S_FLUSH);
        w_hs        = w_ready && bus.vec_valid_i;
        w_flush_end = (r_state == S_FLUSH) && !bus.stall_i && (r_cnt == CNT_W'(1));
        w_event     = w_hs || ((r_state == S_FLUSH) && !bus.stall_i);
        w_final     = w_flush_end || (w_hs && bus.vec_last_i && (N_ROWS == 1));
    end

    // Column entering the skew line: the accepted vector, or zeros while flushing.
    always_comb begin
        for (int r = 0; r < N_ROWS; r++) begin
            w_inj[r] = (r_state == S_FLUSH) ? {DATA_WIDTH{1'b0}}
                                            : bus.vec_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_lane[0] = w_inj[0];

    for (genvar r = 1; r < N_ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_stg [r];

        // Lane r delays its element by r pump events; emptied as a flush ends.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < r; i++) r_stg[i] <= {DATA_WIDTH{1'b0}};
            end else if (w_flush_end) begin
                for (int i = 0; i < r; i++) r_stg[i] <= {DATA_WIDTH{1'b0}};
            end else if (w_event) begin
                r_stg[0] <= w_inj[r];
                for (int i = 1; i < r; i++) r_stg[i] <= r_stg[i-1];
            end
        end

        assign w_lane[r] = r_stg[r-1];
    end

    always_comb begin
        w_lane_flat = {(N_ROWS*DATA_WIDTH){1'b0}};
        for (int r = 0; r < N_ROWS; r++) begin
            w_lane_flat[r*DATA_WIDTH +: DATA_WIDTH] = w_lane[r];
        end
    end

    // Burst sequencing plus the registered array-facing outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_pump  <= 1'b0;
            r_done  <= 1'b0;
            r_ctrl  <= sa_ctrl_t'(4'd0);
            r_data  <= {(N_ROWS*DATA_WIDTH){1'b0}};
        end else begin
            r_pump <= w_event;
            r_done <= w_final;
            if (w_event) begin
                r_data <= w_lane_flat;
            end
            if (w_hs && (r_state == S_IDLE)) begin
                r_ctrl <= bus.sa_ctrl_i;
            end
            case (r_state)
                S_IDLE, S_STREAM: begin
                    if (w_hs) begin
                        if (bus.vec_last_i) begin
                            if (N_ROWS == 1) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_FLUSH;
                                r_cnt   <= FLUSH_LOAD;
                            end
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!bus.stall_i) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.vec_ready_o = w_ready;
    assign bus.pump_o      = r_pump;
    assign bus.done_o      = r_done;
    assign bus.sa_ctrl_o   = r_ctrl;
    assign bus.data_o      = r_data;
    assign bus.busy_o      = (r_state != S_IDLE) || r_pump;

endmodule

// File: tb/tb_sa_data_feeder.sv
// Scoreboard bench for sa_data_feeder: a 4-row and a 1-row instance driven
// with directed and random bursts, checked against a beat/pump mapping model.
module tb_sa_data_feeder;
    import matrix_cps_pkg::*;

    localparam int DW = 32;
    localparam int W4 = 4 * DW;

    logic clk;
    logic rst;
    int   checks    = 0;
    int   errors    = 0;
    bit   mon_ignore = 1'b0;
    int   pump_cnt4 = 0;
    int   run4      = 0;
    int   run_max4  = 0;
    int   pump_cnt1 = 0;

    sa_data_feeder_if #(.DATA_WIDTH(DW), .N_ROWS(4)) bus4 ();
    sa_data_feeder_if #(.DATA_WIDTH(DW), .N_ROWS(1)) bus1 ();

    sa_data_feeder #(.DATA_WIDTH(DW), .N_ROWS(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
    sa_data_feeder #(.DATA_WIDTH(DW), .N_ROWS(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    typedef struct packed {
        logic [W4-1:0] data;
        logic          done;
        sa_ctrl_t      ctrl;
    } exp_t;

    exp_t          q4[$];
    exp_t          q1[$];
    logic [W4-1:0] bq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string nm, input logic [W4-1:0] act, input logic [W4-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event occurred where none was required", nm);
    endtask

    // Pump k of a B-beat burst on an n-row array carries beat[k-r] on lane r.
    function automatic void model_burst(input int n, input sa_ctrl_t c);
        int b;
        b = bq.size();
        for (int k = 0; k < b + n - 1; k++) begin
            exp_t e;
            e.data = '0;
            for (int r = 0; r < n; r++) begin
                if (k - r >= 0 && k - r < b) e.data[r*DW +: DW] = bq[k-r][r*DW +: DW];
            end
            e.done = (k == b + n - 2);
            e.ctrl = c;
            if (n == 1) q1.push_back(e);
            else        q4.push_back(e);
        end
    endfunction

    task automatic send4(input sa_ctrl_t c, input int gap_pct, input int stall_pct);
        int       i;
        int       guard;
        logic [3:0] rc;
        i = 0;
        guard = 0;
        model_burst(4, c);
        while (i < bq.size() && guard < 1000) begin
            @(posedge clk); #1;
            rc = 4'($urandom_range(15));
            bus4.stall_i     = ($urandom_range(99) < stall_pct);
            bus4.vec_valid_i = ($urandom_range(99) >= gap_pct);
            bus4.vec_data_i  = bq[i];
            bus4.vec_last_i  = (i == bq.size() - 1);
            bus4.sa_ctrl_i   = (i == 0) ? c : sa_ctrl_t'(rc);
            @(negedge clk);
            if (bus4.vec_valid_i && bus4.vec_ready_o) i++;
            guard++;
        end
        check_eq("send_timeout", W4'(guard >= 1000), W4'(0));
    endtask

    task automatic drive_beat4(input logic v, input logic [W4-1:0] d, input logic l, input sa_ctrl_t c);
        @(posedge clk); #1;
        bus4.vec_valid_i = v;
        bus4.vec_data_i  = d;
        bus4.vec_last_i  = l;
        bus4.sa_ctrl_i   = c;
        bus4.stall_i     = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(posedge clk); #1;
        bus4.vec_valid_i = 1'b0;
        bus4.stall_i     = 1'b0;
        bus1.vec_valid_i = 1'b0;
        bus1.stall_i     = 1'b0;
        while ((q4.size() != 0 || q1.size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain_timeout", W4'(g >= 1000), W4'(0));
        check_eq("busy4_idle", W4'(bus4.busy_o), W4'(0));
        check_eq("busy1_idle", W4'(bus1.busy_o), W4'(0));
    endtask

    // Monitor: pops the scoreboard on every pump and checks hold/stall rules.
    initial begin : monitor
        logic [W4-1:0] last4;
        logic [DW-1:0] last1;
        bit            sp4;
        bit            sp1;
        exp_t          e;
        last4 = '0; last1 = '0; sp4 = 1'b0; sp1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last4 = '0; last1 = '0; sp4 = 1'b0; sp1 = 1'b0; run4 = 0;
            end else if (!mon_ignore) begin
                if (sp4) check_eq("stall_nopump4", W4'(bus4.pump_o), W4'(0));
                if (bus4.stall_i) check_eq("stall_ready4", W4'(bus4.vec_ready_o), W4'(0));
                if (bus4.pump_o) begin
                    pump_cnt4++;
                    run4++;
                    if (run4 > run_max4) run_max4 = run4;
                    check_eq("busy4", W4'(bus4.busy_o), W4'(1));
                    if (q4.size() == 0) begin
                        fail_now("unexpected_pump4");
                    end else begin
                        e = q4.pop_front();
                        check_eq("data4", bus4.data_o, e.data);
                        check_eq("done4", W4'(bus4.done_o), W4'(e.done));
                        check_eq("ctrl4", W4'(bus4.sa_ctrl_o), W4'(e.ctrl));
                    end
                end else begin
                    run4 = 0;
                    check_eq("hold4", bus4.data_o, last4);
                    check_eq("done_nopump4", W4'(bus4.done_o), W4'(0));
                end
                last4 = bus4.data_o;
                sp4   = bus4.stall_i;

                if (sp1) check_eq("stall_nopump1", W4'(bus1.pump_o), W4'(0));
                if (!bus1.stall_i) check_eq("ready1_noflush", W4'(bus1.vec_ready_o), W4'(1));
                if (bus1.pump_o) begin
                    pump_cnt1++;
                    if (q1.size() == 0) begin
                        fail_now("unexpected_pump1");
                    end else begin
                        e = q1.pop_front();
                        check_eq("data1", W4'(bus1.data_o), e.data);
                        check_eq("done1", W4'(bus1.done_o), W4'(e.done));
                    end
                end else begin
                    check_eq("hold1", W4'(bus1.data_o), W4'(last1));
                end
                last1 = bus1.data_o;
                sp1   = bus1.stall_i;
            end
        end
    end

    initial begin : stimulus
        logic [W4-1:0] va;
        logic [W4-1:0] vb;
        sa_ctrl_t      c32;
        sa_ctrl_t      c8;
        sa_ctrl_t      cr;
        logic [3:0]    rc;
        int            n;

        va  = 128'h00000013_00000012_00000011_00000010;
        vb  = 128'h00000023_00000022_00000021_00000020;
        c32 = '{op: 2'd1, dtype: DT_INT32};
        c8  = '{op: 2'd1, dtype: DT_INT8};

        rst = 1'b1;
        bus4.vec_valid_i = 1'b0; bus4.vec_data_i = '0; bus4.vec_last_i = 1'b0;
        bus4.sa_ctrl_i = c32; bus4.stall_i = 1'b0;
        bus1.vec_valid_i = 1'b0; bus1.vec_data_i = '0; bus1.vec_last_i = 1'b0;
        bus1.sa_ctrl_i = c32; bus1.stall_i = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_pump4", W4'(bus4.pump_o), W4'(0));
        check_eq("rst_data4", bus4.data_o, W4'(0));
        check_eq("rst_busy4", W4'(bus4.busy_o), W4'(0));
        check_eq("rst_pump1", W4'(bus1.pump_o), W4'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", W4'(bus4.vec_ready_o), W4'(1));

        // Reset asserted in the middle of a burst discards it.
        mon_ignore = 1'b1;
        drive_beat4(1'b1, va, 1'b0, '{op: 2'd3, dtype: DT_INT16});
        drive_beat4(1'b1, vb, 1'b0, c8);
        @(posedge clk); #1;
        bus4.vec_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_pump", W4'(bus4.pump_o), W4'(0));
        check_eq("midrst_data", bus4.data_o, W4'(0));
        check_eq("midrst_ctrl", W4'(bus4.sa_ctrl_o), W4'(0));
        check_eq("midrst_done", W4'(bus4.done_o), W4'(0));
        check_eq("midrst_busy", W4'(bus4.busy_o), W4'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", W4'(bus4.vec_ready_o), W4'(1));
        check_eq("midrst_busy_after", W4'(bus4.busy_o), W4'(0));
        mon_ignore = 1'b0;

        // Two-beat burst, no gaps or stalls.
        pump_cnt4 = 0;
        bq.delete(); bq.push_back(va); bq.push_back(vb);
        send4(c32, 0, 0);
        drain();
        check_eq("two_beat_pumps", W4'(pump_cnt4), W4'(5));

        // Same burst with two idle cycles between the beats.
        bq.delete(); bq.push_back(va); bq.push_back(vb);
        model_burst(4, c32);
        drive_beat4(1'b1, va, 1'b0, c32);
        drive_beat4(1'b0, vb, 1'b0, c8);
        drive_beat4(1'b0, vb, 1'b0, c8);
        @(negedge clk);
        check_eq("gap_pump", W4'(bus4.pump_o), W4'(0));
        check_eq("gap_hold", bus4.data_o, W4'(128'h10));
        drive_beat4(1'b1, vb, 1'b1, c8);
        drain();

        // Three stall cycles inside the flush.
        pump_cnt4 = 0;
        bq.delete(); bq.push_back(va); bq.push_back(vb);
        model_burst(4, c32);
        drive_beat4(1'b1, va, 1'b0, c32);
        drive_beat4(1'b1, vb, 1'b1, c32);
        n = 0;
        fork
            begin
                @(posedge clk); #1;
                bus4.vec_valid_i = 1'b0;
                bus4.stall_i = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus4.stall_i = 1'b0;
            end
            begin
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus4.done_o && n < 50);
            end
        join
        check_eq("flush_stall_done_delay", W4'(n), W4'(8));
        drain();
        check_eq("flush_stall_pumps", W4'(pump_cnt4), W4'(5));

        // Back-to-back single-beat bursts with a datatype change.
        pump_cnt4 = 0;
        run_max4  = 0;
        bq.delete(); bq.push_back({$urandom, $urandom, $urandom, $urandom});
        send4(c32, 0, 0);
        bq.delete(); bq.push_back({$urandom, $urandom, $urandom, $urandom});
        send4(c8, 0, 0);
        drain();
        check_eq("b2b_pumps", W4'(pump_cnt4), W4'(8));
        check_eq("b2b_contiguous", W4'(run_max4), W4'(8));

        // Randomized bursts with valid gaps and stalls.
        for (int t = 0; t < 30; t++) begin
            bq.delete();
            n = 1 + int'($urandom_range(5));
            for (int j = 0; j < n; j++) bq.push_back({$urandom, $urandom, $urandom, $urandom});
            rc = 4'($urandom_range(15));
            cr = sa_ctrl_t'(rc);
            send4(cr, int'($urandom_range(40)), int'($urandom_range(30)));
            repeat (int'($urandom_range(2))) begin
                @(posedge clk); #1;
                bus4.vec_valid_i = 1'b0;
                bus4.stall_i = ($urandom_range(99) < 30);
            end
        end
        drain();

        // Single-row build: three beats, one idle cycle in between.
        pump_cnt1 = 0;
        bq.delete();
        for (int j = 0; j < 3; j++) bq.push_back(W4'($urandom));
        model_burst(1, c8);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            bus1.vec_valid_i = 1'b1;
            bus1.vec_data_i  = bq[j][DW-1:0];
            bus1.vec_last_i  = (j == 2);
            bus1.sa_ctrl_i   = c8;
            if (j == 0) begin
                @(posedge clk); #1;
                bus1.vec_valid_i = 1'b0;
            end
        end
        drain();
        check_eq("n1_pumps", W4'(pump_cnt1), W4'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_data_feeder.md
# sa_data_feeder

Left-edge transmitter for the systolic array. It accepts row-vectors over a valid/ready handshake and drives the per-row `data_i` lanes, the global `pump_i` and `sa_ctrl_i` of the array's first PE column. It applies the triangular skew: lane r is delayed by r pump events. After the last vector it injects zero columns until the final element has entered the array. One instance sits between the operand buffer and PE column 0.

## Interface
- `DATA_WIDTH`, 32: width of one lane element.
- `N_ROWS`, 4: number of array rows (lanes), ≥1.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `vec_valid_i`  in  1  a vector is offered.
- `vec_ready_o`  out  1  vector accepted when both valid and ready are high.
- `vec_data_i`  in  N_ROWS*DATA_WIDTH  element r is bits [r*DATA_WIDTH +: DATA_WIDTH].
- `vec_last_i`  in  1  the offered vector is the final beat of a burst.
- `sa_ctrl_i`  in  matrix_cps_pkg::sa_ctrl_t  op type, sampled on the first beat of a burst.
- `stall_i`  in  1  controller hold (e.g. multi-cycle MAC); freezes the block.
- `pump_o`  out  1  to array `pump_i`.
- `data_o`  out  N_ROWS*DATA_WIDTH  lane r to row r `data_i`.
- `sa_ctrl_o`  out  matrix_cps_pkg::sa_ctrl_t  to column 0 `sa_ctrl_i`.
- `busy_o`  out  1  a burst is in progress.
- `done_o`  out  1  one-cycle pulse marking the final pump of a burst.

## Operation
- **States.**
  - IDLE: no burst in progress.
  - STREAM: first beat accepted, last beat not yet accepted.
  - FLUSH: injecting zero columns.
- **Ready.** `vec_ready_o = !stall_i && state != FLUSH`. It is combinational.
- **Pump event.** An internal, unregistered event. It occurs in either of these cases:
  - a handshake in IDLE or STREAM;
  - any cycle in FLUSH with `!stall_i`.
- **Skew line.** Lane r has r stages and advances only on pump events.
  - The injected column is the accepted vector, or all zeros in FLUSH.
  - Lane-r output takes element r of the column injected r events earlier. If fewer than r+1 columns have been injected this burst, it takes 0.
- **Lane mapping.** For a burst of B beats, output pump k (k = 0 … B+N_ROWS−2) carries on lane r: element r of beat k−r if 0 ≤ k−r < B, else 0.
- **Pumps per burst.** Exactly B+N_ROWS−1.
- **IDLE → STREAM.** On a handshake with `vec_last_i=0`.
  - The IDLE handshake captures `sa_ctrl_i` into `sa_ctrl_o`.
  - The skew line starts from all zeros: residue is cleared when FLUSH ends.
- **STREAM or IDLE → FLUSH.** On a handshake with `vec_last_i=1`. The flush counter loads N_ROWS−1.
  - If N_ROWS=1, the state goes directly to IDLE and no FLUSH occurs.
- **FLUSH.** Each non-stalled cycle is a pump event and decrements the counter. The event with counter = 1 returns the state to IDLE.
- **No-valid cycles in STREAM** produce no event. The array holds.
- **sa_ctrl_o** holds until the next IDLE handshake.
- **`vec_valid_i` while ready is low** has no effect. The source must hold its data.

## Timing
- **Output registers.** `pump_o`, `data_o`, `sa_ctrl_o` and `done_o` are registered.
  - A pump event in cycle t gives `pump_o=1` in t+1, with the lane values defined above.
  - `data_o` holds its last value when `pump_o=0`.
- **done_o** is high in the same cycle as the final `pump_o` of a burst.
- **busy_o** = (state != IDLE) || `pump_o`.
- **Back-to-back bursts.** The first beat of the next burst can be accepted in the cycle `done_o` is high. `pump_o` then stays continuous.
- **stall_i = 1.**
  - No handshake and no event occur.
  - `pump_o=0` in the next cycle.
  - State, counter, skew stages and `data_o` are frozen.
- **Reset.**
  - Values while reset is asserted: `pump_o`=0, `data_o`=0, `sa_ctrl_o`='0, `done_o`=0, `busy_o`=0, state IDLE, skew stages 0.
  - `vec_ready_o` = `!stall_i` as soon as the state is IDLE.
  - Reset mid-burst discards all partial data. The first post-reset beat starts a fresh burst.
- **Throughput.** One vector per cycle in STREAM. Latency from handshake to lane-0 appearance is one cycle.

## Test plan
- **Reset.** Assert `rst_i` mid-STREAM.
  - During reset: all outputs 0 and `busy_o`=0.
  - After release, with `stall_i`=0 and state IDLE: `vec_ready_o`=1.
- **Two-beat burst.** N_ROWS=4. Beat A = {0x10,0x11,0x12,0x13} (lane0 first), then B = {0x20..0x23} with last, no stalls. Required: 5 consecutive `pump_o` cycles with lanes:
  - (0x10,0,0,0)
  - (0x20,0x11,0,0)
  - (0,0x21,0x12,0)
  - (0,0,0x22,0x13)
  - (0,0,0,0x23), with `done_o`=1 in this cycle.
- **Valid gaps.** The same burst with two idle cycles between A and B. Required:
  - `pump_o`=0 for two cycles, with `data_o` held at (0x10,0,0,0);
  - then the sequence resumes unchanged.
- **Flush stall.** Assert `stall_i` for 3 cycles during FLUSH. Required:
  - `pump_o`=0 and `vec_ready_o`=0 for those cycles;
  - total pumps still 5;
  - `done_o` delayed by 3 cycles.
- **Back-to-back bursts.** Two single-beat bursts with datatypes 32-bit then 8-bit. Required:
  - 8 contiguous pumps;
  - `sa_ctrl_o` switches to 8-bit in the cycle of the second burst's first pump;
  - no residue from the first burst appears in the second.
- **N_ROWS=1 build.** A 3-beat burst gives exactly 3 pumps, no FLUSH, and `done_o` on the third pump.
